nios_cpu_debug_cmd_dispatch: RTL

- Sysclk-side successor to the single-IR debug-slave command decoder.
- Synchronises the TCK-domain update strobes and captures the scanned data register.
- Generalises the IR to IR_W bits, giving 2**IR_W command channels.
- Queues commands in a DEPTH-entry FIFO and presents them to the CPU debug logic with a valid/ready handshake, instead of fire-and-forget take_action pulses.

---
 rtl/nios_cpu_debug_cmd_dispatch.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/nios_cpu_debug_cmd_dispatch.sv
// Debug command dispatcher: synchronises TCK-domain UIR/E1DR strobes and queues scanned commands
// for the CPU debug logic behind a valid/ready handshake. Define DEBUG_CMD_TIMEOUT_EN to discard stalled heads.
module nios_cpu_debug_cmd_dispatch #(
    parameter int IR_W        = 2,
    parameter int SR_W        = 38,
    parameter int ACTION_BIT  = 34,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [IR_W-1:0]        ir_in,
    input  logic [SR_W-1:0]        sr,
    input  logic                   vs_uir,
    input  logic                   vs_e1dr,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    output logic [IR_W-1:0]        cmd_ch,
    output logic                   cmd_action,
    output logic [SR_W-1:0]        jdo,
    output logic [IR_W-1:0]        ir_latched,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overrun,
    input  logic                   err_clr,
    output logic                   timeout
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = IR_W + 1 + SR_W;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || SYNC_STAGES < 2 ||
        ACTION_BIT >= SR_W || TIMEOUT_CYC < 2) begin : g_param_check
        $error("nios_cpu_debug_cmd_dispatch: invalid parameter set");
    end

    logic [SYNC_STAGES-1:0] uir_sync_q, e1dr_sync_q;
    logic                   uir_dly_q, e1dr_dly_q;
    logic [SYNC_STAGES:0]   prime_q;
    logic                   uir_rise, e1dr_rise;

    // prime_q tracks when the chain and delay flop hold real samples, so a strobe that is
    // already high as reset releases is not taken for a rising edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            uir_sync_q  <= '0;
            e1dr_sync_q <= '0;
            uir_dly_q   <= 1'b0;
            e1dr_dly_q  <= 1'b0;
            prime_q     <= '0;
        end else begin
            uir_sync_q  <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
            e1dr_sync_q <= {e1dr_sync_q[SYNC_STAGES-2:0], vs_e1dr};
            uir_dly_q   <= uir_sync_q[SYNC_STAGES-1];
            e1dr_dly_q  <= e1dr_sync_q[SYNC_STAGES-1];
            prime_q     <= {prime_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign uir_rise  = uir_sync_q[SYNC_STAGES-1]  & ~uir_dly_q  & prime_q[SYNC_STAGES];
    assign e1dr_rise = e1dr_sync_q[SYNC_STAGES-1] & ~e1dr_dly_q & prime_q[SYNC_STAGES];

    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]   level_q, level_d;
    logic            cmd_valid_q, overrun_q, timeout_q;
    logic [IR_W-1:0] ir_latched_q, push_ch;
    logic            full, pop, push_ok, ov_set, to_pop;

    // A same-cycle UIR edge bypasses the latch so the command carries the new IR.
    assign push_ch = uir_rise ? ir_in : ir_latched_q;
    assign full    = (level_q == LW'(DEPTH));
    assign pop     = (cmd_valid_q & cmd_ready) | to_pop;
    assign push_ok = e1dr_rise & (~full | pop);
    assign ov_set  = e1dr_rise & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop)
            level_d = level_q + 1'b1;
        else if (!push_ok && pop)
            level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {push_ch, sr[ACTION_BIT], sr};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            cmd_valid_q  <= 1'b0;
            ir_latched_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            if (uir_rise)
                ir_latched_q <= ir_in;
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q     <= level_d;
            cmd_valid_q <= (level_d != '0);
            overrun_q   <= ov_set | (overrun_q & ~err_clr);
        end
    end

`ifdef DEBUG_CMD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC) + 1;
    logic [CW-1:0] wait_cnt_q;

    assign to_pop = cmd_valid_q & ~cmd_ready & (wait_cnt_q == CW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (!cmd_valid_q || pop)
                wait_cnt_q <= '0;
            else
                wait_cnt_q <= wait_cnt_q + 1'b1;
            timeout_q <= to_pop | (timeout_q & ~err_clr);
        end
    end
`else
    assign to_pop    = 1'b0;
    assign timeout_q = 1'b0;
`endif

    // Head fields read as zero while the queue is empty.
    assign {cmd_ch, cmd_action, jdo} = cmd_valid_q ? mem_q[rd_ptr_q] : '0;
    assign cmd_valid  = cmd_valid_q;
    assign level      = level_q;
    assign ir_latched = ir_latched_q;
    assign overrun    = overrun_q;
    assign timeout    = timeout_q;
endmodule
